mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_defs.sv | 32 +++
 rtl/mem_align.sv | 67 ++++++
 rtl/mem_stage.sv | 110 +++++++++++
 tb/tb_mem_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_defs.sv
// Shared definitions for the MEM stage: load/store op codes, bus size codes, FSM states.
package mem_defs;

  localparam logic [3:0] LsopNop = 4'd0;
  localparam logic [3:0] LsopLb  = 4'd1;
  localparam logic [3:0] LsopLbu = 4'd2;
  localparam logic [3:0] LsopLh  = 4'd3;
  localparam logic [3:0] LsopLhu = 4'd4;
  localparam logic [3:0] LsopLw  = 4'd5;
  localparam logic [3:0] LsopSb  = 4'd6;
  localparam logic [3:0] LsopSh  = 4'd7;
  localparam logic [3:0] LsopSw  = 4'd8;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= LsopLb) && (op <= LsopLw);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= LsopSb) && (op <= LsopSw);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store strobes/data replication and load extraction/extension.
module mem_align
  import mem_defs::*;
(
  input  logic [3:0]  lsop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Halves select on addr_lo[1] only, so a misaligned half falls back to its aligned lane.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = load_word[7:0];
      2'd1:    byte_v = load_word[15:8];
      2'd2:    byte_v = load_word[23:16];
      default: byte_v = load_word[31:24];
    endcase
    half_v = addr_lo[1] ? load_word[31:16] : load_word[15:0];
  end

  always_comb begin
    size      = SizeByte;
    wstrb     = 4'b0000;
    wdata     = 32'h0;
    load_data = 32'h0;
    case (lsop)
      LsopLb:  load_data = {{24{byte_v[7]}}, byte_v};
      LsopLbu: load_data = {24'h0, byte_v};
      LsopLh: begin
        size      = SizeHalf;
        load_data = {{16{half_v[15]}}, half_v};
      end
      LsopLhu: begin
        size      = SizeHalf;
        load_data = {16'h0, half_v};
      end
      LsopLw: begin
        size      = SizeWord;
        load_data = load_word;
      end
      LsopSb: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      LsopSh: begin
        size  = SizeHalf;
        wdata = {2{store_data[15:0]}};
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      LsopSw: begin
        size  = SizeWord;
        wdata = store_data;
        wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives a req/addr_ok/data_ok data bus and aligns results for writeback.
// Optional misalignment exception enabled by defining MEM_ADDR_EXC_EN.
module mem_stage
  import mem_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_wdata_i,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [3:0]  mem_lsop_i,
  input  logic [31:0] mem_memaddr_i,
  input  logic [31:0] mem_reg2_i,
  input  logic [31:0] mem_pc_i,
  input  logic        stall_i,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] wb_wdata_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_pc_o,
  output logic        stallreq_mem_o,
  output logic        addr_exc_o
);

  state_e      state_q, state_d;
  logic [31:0] rdata_q;
  logic        op_load, op_store, pending;
  logic [3:0]  wstrb_raw;
  logic [31:0] load_data;

  assign op_load  = is_load(mem_lsop_i);
  assign op_store = is_store(mem_lsop_i);

`ifdef MEM_ADDR_EXC_EN
  logic misalign;
  always_comb begin
    case (mem_lsop_i)
      LsopLh, LsopLhu, LsopSh: misalign = mem_memaddr_i[0];
      LsopLw, LsopSw:          misalign = |mem_memaddr_i[1:0];
      default:                 misalign = 1'b0;
    endcase
  end
  assign addr_exc_o = misalign;
`else
  assign addr_exc_o = 1'b0;
`endif

  assign pending = (op_load | op_store) & ~addr_exc_o;

  mem_align u_align (
    .lsop       (mem_lsop_i),
    .addr_lo    (mem_memaddr_i[1:0]),
    .store_data (mem_reg2_i),
    .load_word  (rdata_q),
    .size       (data_size),
    .wstrb      (wstrb_raw),
    .wdata      (data_wdata),
    .load_data  (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Only a WAIT-state data_ok is a response to our request; stray ones are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'h0;
    end else if ((state_q == StWait) && data_data_ok) begin
      rdata_q <= data_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (pending && data_addr_ok) state_d = StWait;
      StWait:  if (data_data_ok) state_d = StDone;
      StDone:  if (!stall_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_req       = (state_q == StIdle) && pending && !rst;
    stallreq_mem_o = pending && (state_q != StDone);
  end

  assign data_wr    = op_store & pending;
  assign data_wstrb = pending ? wstrb_raw : 4'b0000;
  assign data_addr  = {mem_memaddr_i[31:2], 2'b00};

  assign wb_wdata_o = op_load ? load_data : mem_wdata_i;
  assign wb_wreg_o  = mem_wreg_i & ~addr_exc_o;
  assign wb_wd_o    = mem_wd_i;
  assign wb_pc_o    = mem_pc_i;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table run through a bus responder, plus
// hand sequences for reset during a transaction and the MEM_ADDR_EXC_EN option.
module tb_mem_stage;
  import mem_defs::*;

  logic        clk, rst;
  logic [31:0] mem_wdata_i, mem_memaddr_i, mem_reg2_i, mem_pc_i;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i, stall_i;
  logic [3:0]  mem_lsop_i;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] wb_wdata_o, wb_pc_o;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o, stallreq_mem_o, addr_exc_o;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .mem_wdata_i    (mem_wdata_i),
    .mem_wd_i       (mem_wd_i),
    .mem_wreg_i     (mem_wreg_i),
    .mem_lsop_i     (mem_lsop_i),
    .mem_memaddr_i  (mem_memaddr_i),
    .mem_reg2_i     (mem_reg2_i),
    .mem_pc_i       (mem_pc_i),
    .stall_i        (stall_i),
    .data_req       (data_req),
    .data_wr        (data_wr),
    .data_size      (data_size),
    .data_wstrb     (data_wstrb),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_addr_ok   (data_addr_ok),
    .data_data_ok   (data_data_ok),
    .data_rdata     (data_rdata),
    .wb_wdata_o     (wb_wdata_o),
    .wb_wd_o        (wb_wd_o),
    .wb_wreg_o      (wb_wreg_o),
    .wb_pc_o        (wb_pc_o),
    .stallreq_mem_o (stallreq_mem_o),
    .addr_exc_o     (addr_exc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  logic [143:0] all_out;
  assign all_out = {data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, wb_wdata_o,
                    wb_wd_o, wb_wreg_o, wb_pc_o, stallreq_mem_o, addr_exc_o};

  typedef struct {
    string       name;
    logic [3:0]  lsop;
    logic [31:0] addr, reg2, alu, rdata;
    int          delay, stall;
    logic [31:0] exp_wb, exp_daddr, exp_dwdata;
    logic [3:0]  exp_wstrb;
    logic        exp_wr;
    logic [1:0]  exp_size;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [3:0] lsop, input logic [31:0] addr,
                              input logic [31:0] reg2, input logic [31:0] alu,
                              input logic [31:0] rdata, input int delay, input int stall,
                              input logic [31:0] exp_wb, input logic [31:0] exp_daddr,
                              input logic [31:0] exp_dwdata, input logic [3:0] exp_wstrb,
                              input logic exp_wr, input logic [1:0] exp_size);
    vec_t v;
    v.name = name; v.lsop = lsop; v.addr = addr; v.reg2 = reg2; v.alu = alu; v.rdata = rdata;
    v.delay = delay; v.stall = stall; v.exp_wb = exp_wb; v.exp_daddr = exp_daddr;
    v.exp_dwdata = exp_dwdata; v.exp_wstrb = exp_wstrb; v.exp_wr = exp_wr; v.exp_size = exp_size;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    mem_wdata_i = '0; mem_wd_i = '0; mem_wreg_i = 1'b0; mem_lsop_i = '0; mem_memaddr_i = '0;
    mem_reg2_i = '0; mem_pc_i = '0; stall_i = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
  endtask

  // Entered and left at posedge+1; the bench plays the bus slave.
  task automatic run_vec(input vec_t v);
    logic [31:0] exp;
    bit mem_op;
    int req_cnt;
    int stl_cnt;
    bit done;
    mem_op  = (v.lsop >= 4'd1) && (v.lsop <= 4'd8);
    req_cnt = 0;
    stl_cnt = 0;
    done    = 1'b0;
    mem_lsop_i = v.lsop; mem_memaddr_i = v.addr; mem_reg2_i = v.reg2; mem_wdata_i = v.alu;
    mem_wd_i = 5'h13; mem_wreg_i = 1'b1; mem_pc_i = 32'h8000_0040;
    exp_q.push_back(v.exp_wb);
    #1;
    for (int c = 0; c < 20 && !done; c++) begin
      if (!stallreq_mem_o) begin
        done = 1'b1;
      end else begin
        stl_cnt++;
        if (data_req) begin
          req_cnt++;
          if (req_cnt == 1) begin
            chk({v.name, "_addr"}, data_addr, v.exp_daddr);
            chk({v.name, "_wdata"}, data_wdata, v.exp_dwdata);
            chk({v.name, "_wstrb"}, {28'h0, data_wstrb}, {28'h0, v.exp_wstrb});
            chk({v.name, "_wr_size"}, {29'h0, data_wr, data_size}, {29'h0, v.exp_wr, v.exp_size});
          end
          data_addr_ok = (req_cnt > v.delay);
        end else begin
          data_data_ok = 1'b1;
          data_rdata   = v.rdata;
        end
        @(posedge clk); #1;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
        #1;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got stallreq stuck expected release within 20 cycles", v.name);
    end
    chk({v.name, "_req_cycles"}, 32'(req_cnt), mem_op ? 32'(v.delay + 1) : 32'd0);
    chk({v.name, "_stall_cycles"}, 32'(stl_cnt), mem_op ? 32'(v.delay + 2) : 32'd0);
    exp = exp_q.pop_front();
    chk({v.name, "_wb_wdata"}, wb_wdata_o, exp);
    chk({v.name, "_wb_ctl"}, {25'h0, wb_wreg_o, addr_exc_o, wb_wd_o}, {25'h0, 2'b10, 5'h13});
    chk({v.name, "_wb_pc"}, wb_pc_o, 32'h8000_0040);
    stall_i = 1'b1;
    for (int s = 0; s < v.stall; s++) begin
      data_data_ok = 1'b1; data_rdata = $urandom;
      @(posedge clk); #1;
      data_data_ok = 1'b0;
      #1;
      chk({v.name, "_stall_req"}, {30'h0, data_req, stallreq_mem_o}, 32'h0);
      chk({v.name, "_stall_hold"}, wb_wdata_o, exp);
    end
    stall_i = 1'b0;
    @(posedge clk); #1;
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    //   name     op       addr          reg2          alu           rdata       dly st
    //   exp_wb        daddr         dwdata        wstrb  wr size
    vecs.push_back(mk("lw",   LsopLw,  32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 0, 0,
                      32'hDEADBEEF, 32'h100, 32'h0, 4'b0000, 1'b0, 2'd2));
    vecs.push_back(mk("lb",   LsopLb,  32'h103, 32'h0, 32'h0, 32'h80112233, 0, 0,
                      32'hFFFFFF80, 32'h100, 32'h0, 4'b0000, 1'b0, 2'd0));
    vecs.push_back(mk("lbu",  LsopLbu, 32'h103, 32'h0, 32'h0, 32'h80112233, 1, 0,
                      32'h00000080, 32'h100, 32'h0, 4'b0000, 1'b0, 2'd0));
    vecs.push_back(mk("lb1",  LsopLb,  32'h101, 32'h0, 32'h0, 32'h80112233, 0, 0,
                      32'h00000022, 32'h100, 32'h0, 4'b0000, 1'b0, 2'd0));
    vecs.push_back(mk("lh",   LsopLh,  32'h102, 32'h0, 32'h0, 32'h80112233, 0, 0,
                      32'hFFFF8011, 32'h100, 32'h0, 4'b0000, 1'b0, 2'd1));
    vecs.push_back(mk("lhu",  LsopLhu, 32'h100, 32'h0, 32'h0, 32'h80118233, 0, 0,
                      32'h00008233, 32'h100, 32'h0, 4'b0000, 1'b0, 2'd1));
    vecs.push_back(mk("sb",   LsopSb,  32'h101, 32'hA5, 32'h11110000, 32'h0, 0, 0,
                      32'h11110000, 32'h100, 32'hA5A5A5A5, 4'b0010, 1'b1, 2'd0));
    vecs.push_back(mk("sh",   LsopSh,  32'h202, 32'hABCD, 32'h22220000, 32'h0, 0, 0,
                      32'h22220000, 32'h200, 32'hABCDABCD, 4'b1100, 1'b1, 2'd1));
    vecs.push_back(mk("sw",   LsopSw,  32'h30C, 32'h12345678, 32'h33330000, 32'h0, 0, 0,
                      32'h33330000, 32'h30C, 32'h12345678, 4'b1111, 1'b1, 2'd2));
    vecs.push_back(mk("lw_slow", LsopLw, 32'h110, 32'h0, 32'h0, 32'h13579BDF, 3, 2,
                      32'h13579BDF, 32'h110, 32'h0, 4'b0000, 1'b0, 2'd2));
    vecs.push_back(mk("nop",  LsopNop, 32'h44, 32'h0, 32'hCAFEF00D, 32'h0, 0, 0,
                      32'hCAFEF00D, 32'h0, 32'h0, 4'b0000, 1'b0, 2'd0));
    vecs.push_back(mk("op12", 4'd12,   32'h48, 32'h0, 32'h0BADF00D, 32'h0, 0, 0,
                      32'h0BADF00D, 32'h0, 32'h0, 4'b0000, 1'b0, 2'd0));
`ifndef MEM_ADDR_EXC_EN
    vecs.push_back(mk("lw_mis", LsopLw, 32'h101, 32'h0, 32'h0, 32'h01020304, 0, 0,
                      32'h01020304, 32'h100, 32'h0, 4'b0000, 1'b0, 2'd2));
    vecs.push_back(mk("sh_mis", LsopSh, 32'h203, 32'h1234, 32'h55550000, 32'h0, 0, 0,
                      32'h55550000, 32'h200, 32'h12341234, 4'b1100, 1'b1, 2'd1));
`endif

    drive_idle();
    rst = 1'b1;
    #3;
    chk("reset_all_zero", 32'(|all_out), 32'h0);
    mem_lsop_i = LsopLw;
    #1;
    chk("reset_no_req", {31'h0, data_req}, 32'h0);
    mem_lsop_i = LsopNop;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_reset_all_zero", 32'(|all_out), 32'h0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while waiting for data: the late data_ok must not be captured.
    mem_lsop_i = LsopLw; mem_memaddr_i = 32'h100; mem_wreg_i = 1'b1;
    #1;
    chk("rst_seq_req", {31'h0, data_req}, 32'h1);
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    #1;
    chk("rst_seq_wait", {30'h0, data_req, stallreq_mem_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_seq_req_gated", {31'h0, data_req}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555AAAA;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    #1;
    chk("rst_seq_idle", {30'h0, data_req, stallreq_mem_o}, 32'h3);
    chk("rst_seq_no_capture", wb_wdata_o, 32'h0);
    drive_idle();
    #1;
    chk("rst_seq_all_zero", 32'(|all_out), 32'h0);
    @(posedge clk); #1;

`ifdef MEM_ADDR_EXC_EN
    mem_lsop_i = LsopLw; mem_memaddr_i = 32'h101; mem_wreg_i = 1'b1;
    #1;
    chk("exc_lw", {28'h0, addr_exc_o, data_req, stallreq_mem_o, wb_wreg_o}, 32'h8);
    mem_lsop_i = LsopSh; mem_memaddr_i = 32'h203;
    #1;
    chk("exc_sh", {28'h0, addr_exc_o, data_req, stallreq_mem_o, wb_wreg_o}, 32'h8);
    mem_lsop_i = LsopLh; mem_memaddr_i = 32'h202;
    #1;
    chk("exc_lh_aligned", {28'h0, addr_exc_o, data_req, stallreq_mem_o, wb_wreg_o}, 32'h7);
    drive_idle();
    @(posedge clk); #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
